// File: rtl/neperek_pkg.sv
// neperek_pkg: shared state type and detector pattern for the neperek serial line
package neperek_pkg;
  typedef enum logic [1:0] {TX_IDLE, TX_SHIFT, TX_PAR, TX_GAP} tx_state_t;
  localparam logic [3:0] NEPEREK_PATTERN = 4'b0001;
endpackage

// File: rtl/neperek_seq_tx_if.sv
// neperek_seq_tx_if: word load handshake and serial output bundle
interface neperek_seq_tx_if #(parameter int WORD_W = 4);
  logic [WORD_W-1:0] DATA_IN;
  logic LOAD_VALID;
  logic LOAD_READY;
  logic SER_OUT;
  logic SER_VALID;
  logic FRAME_DONE;
  modport master (output DATA_IN, LOAD_VALID, input LOAD_READY, SER_OUT, SER_VALID, FRAME_DONE);
  modport slave (input DATA_IN, LOAD_VALID, output LOAD_READY, SER_OUT, SER_VALID, FRAME_DONE);
endinterface

// File: rtl/neperek_tx_cnt.sv
// neperek_tx_cnt: loadable down-counter with zero flag, shared by bit and gap counting
module neperek_tx_cnt #(parameter int W = 3) (
  input  logic         clk,
  input  logic         nres,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge nres)
    if (!nres) cnt <= '0;
    else cnt <= load ? val : dec ? cnt - 1'b1 : cnt;
  assign zero = cnt == '0;
endmodule

// File: rtl/neperek_seq_tx.sv
// neperek_seq_tx: MSB-first serial word transmitter; NEPEREK_TX_PARITY_EN appends an even-parity bit
module neperek_seq_tx
  import neperek_pkg::*;
#(
  parameter int WORD_W   = 4,
  parameter int GAP_BITS = 0
) (
  input logic clk,
  input logic nres,
  neperek_seq_tx_if.slave tx
);
`ifdef NEPEREK_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int MX = WORD_W > GAP_BITS ? WORD_W : GAP_BITS;
  localparam int CW = $clog2(MX + 1);
  localparam int GL = GAP_BITS > 0 ? GAP_BITS - 1 : 0;
  tx_state_t state;
  logic [WORD_W-1:0] sreg;
  logic par, zero, accept, last_bit, enter_par, enter_gap;
  assign accept    = tx.LOAD_VALID & tx.LOAD_READY;
  assign last_bit  = state == TX_SHIFT && zero;
  assign enter_par = PAR_EN && last_bit;
  assign enter_gap = GAP_BITS > 0 && (PAR_EN ? state == TX_PAR : last_bit);
  neperek_tx_cnt #(.W(CW)) u_cnt (
    .clk (clk),
    .nres(nres),
    .load(accept | enter_gap),
    .dec ((state == TX_SHIFT || state == TX_GAP) && !zero),
    .val (accept ? CW'(WORD_W - 1) : CW'(GL)),
    .zero(zero)
  );
  // an accept can only happen in idle or the frame's final cycle, so it always starts a fresh frame
  always_ff @(posedge clk or negedge nres)
    if (!nres) begin
      state <= TX_IDLE;
      sreg  <= '0;
      par   <= 1'b0;
    end else begin
      state <= accept ? TX_SHIFT : enter_par ? TX_PAR : enter_gap ? TX_GAP :
               ((state == TX_SHIFT || state == TX_GAP) && !zero) ? state : TX_IDLE;
      sreg  <= accept ? tx.DATA_IN : state == TX_SHIFT ? sreg << 1 : sreg;
      par   <= accept ? ^tx.DATA_IN : par;
    end
  assign tx.SER_OUT    = state == TX_SHIFT ? sreg[WORD_W-1] : state == TX_PAR ? par : 1'b0;
  assign tx.SER_VALID  = state == TX_SHIFT || state == TX_PAR;
  assign tx.FRAME_DONE = PAR_EN ? state == TX_PAR : last_bit;
  assign tx.LOAD_READY = state == TX_IDLE || (GAP_BITS == 0 ? tx.FRAME_DONE : state == TX_GAP && zero);
endmodule

// File: tb/tb_neperek_seq_tx.sv
// tb_neperek_seq_tx: gap-0 and gap-2 transmitters against a queue-of-expected-cycles model
module tb_neperek_seq_tx;
  import neperek_pkg::*;
`ifdef NEPEREK_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int G[2] = '{0, 2};
  logic clk = 1'b0, nres = 1'b0, vld = 1'b0;
  logic [3:0] din = '0;
  int checks = 0, failures = 0;
  logic [2:0] q[2][$];
  always #20 clk = ~clk;
  neperek_seq_tx_if #(.WORD_W(4)) bus0 ();
  neperek_seq_tx_if #(.WORD_W(4)) bus1 ();
  assign bus0.DATA_IN = din;
  assign bus0.LOAD_VALID = vld;
  assign bus1.DATA_IN = din;
  assign bus1.LOAD_VALID = vld;
  neperek_seq_tx #(.WORD_W(4), .GAP_BITS(0)) dut0 (.clk(clk), .nres(nres), .tx(bus0.slave));
  neperek_seq_tx #(.WORD_W(4), .GAP_BITS(2)) dut1 (.clk(clk), .nres(nres), .tx(bus1.slave));
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: {ser,valid,done,ready} got %b want %b at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic logic [3:0] observed(input int i);
    return i == 0 ? {bus0.SER_OUT, bus0.SER_VALID, bus0.FRAME_DONE, bus0.LOAD_READY}
                  : {bus1.SER_OUT, bus1.SER_VALID, bus1.FRAME_DONE, bus1.LOAD_READY};
  endfunction
  function automatic logic [3:0] expected(input int i);
    return {q[i].size() > 0 ? q[i][0] : 3'b000, q[i].size() <= 1};
  endfunction
  task automatic push_frame(input int i, input logic [3:0] w);
    for (int b = 3; b >= 0; b--) q[i].push_back({w[b], 1'b1, !PAR_EN && b == 0});
    if (PAR_EN) q[i].push_back({^w, 1'b1, 1'b1});
    for (int k = 0; k < G[i]; k++) q[i].push_back(3'b000);
  endtask
  task automatic step(input logic v, input logic [3:0] d);
    logic acc;
    chk("gap0", observed(0), expected(0));
    chk("gap2", observed(1), expected(1));
    vld = v;
    din = d;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      acc = vld && q[i].size() <= 1;
      if (q[i].size() > 0) void'(q[i].pop_front());
      if (acc) push_frame(i, din);
    end
    @(negedge clk);
  endtask
  task automatic do_reset();
    #15 nres = 1'b0;
    #1;
    chk("rst0", observed(0), 4'b0001);
    chk("rst1", observed(1), 4'b0001);
    vld = 1'b1;
    din = 4'b1111;
    @(posedge clk);
    vld = 1'b0;
    #1 nres = 1'b1;
    q[0].delete();
    q[1].delete();
    @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    chk("por0", observed(0), 4'b0001);
    chk("por1", observed(1), 4'b0001);
    @(posedge clk);
    #1 nres = 1'b1;
    @(negedge clk);
    step(1'b1, NEPEREK_PATTERN);
    repeat (8) step(1'b0, 4'b0000);
    for (int k = 0; k < 16; k++) step(1'b1, k < 6 ? 4'b0001 : 4'b1001);
    repeat (8) step(1'b0, 4'b0000);
    step(1'b1, 4'b0111);
    step(1'b0, 4'b0000);
    do_reset();
    step(1'b1, 4'b0001);
    repeat (10) step(1'b0, 4'b0000);
    for (int k = 0; k < 400; k++) begin
      if (k == 200) do_reset();
      step($urandom_range(3) != 0, 4'($urandom));
    end
    repeat (10) step(1'b0, 4'b0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
